// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath; strobes are registered from the next state.
// Optional performance counters are built only when CTRL_PERF_CNT_EN is defined.
module multi_cycle_ctrl #(
   parameter logic [5:0] HALT_OPCODE = 6'h3F,
   parameter int         CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_I_EXEC   = 4'd11,
      S_I_WB     = 4'd12,
      S_HALT     = 4'd13
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [1:0] pc_source;
      logic       halted;
   } ctrl_t;

   state_t state_q;
   state_t state_nxt;
   ctrl_t  ctrl_q;
   logic   illegal_q;
   logic   r_funct_ok;
   logic   in_fetch;

   function automatic logic [2:0] alu_from_funct(input logic [5:0] f);
      case (f)
         6'h22:   return ALU_SUB;
         6'h24:   return ALU_AND;
         6'h25:   return ALU_OR;
         6'h2A:   return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   // Strobe pattern for a state; IDLE is all-zero, everything else defaults to add.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] f);
      ctrl_t c;
      c = '0;
      c.alu_ctrl = ALU_ADD;
      case (s)
         S_IDLE: c.alu_ctrl = 3'b000;
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b11;
         S_MEM_ADDR, S_I_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_ctrl  = alu_from_funct(f);
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_ctrl      = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         S_I_WB:  c.reg_write = 1'b1;
         S_HALT:  c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      r_funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                   (funct == 6'h25) || (funct == 6'h2A);
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (opcode == OP_RTYPE && r_funct_ok)         state_nxt = S_R_EXEC;
            else if (opcode == OP_LW || opcode == OP_SW)  state_nxt = S_MEM_ADDR;
            else if (opcode == OP_BEQ)                    state_nxt = S_BRANCH;
            else if (opcode == OP_J)                      state_nxt = S_JUMP;
            else if (opcode == OP_ADDI)                   state_nxt = S_I_EXEC;
            else if (opcode == HALT_OPCODE)               state_nxt = S_HALT;
            else                                          state_nxt = S_FETCH;
         end
         S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   state_nxt = S_R_WB;
         S_I_EXEC:   state_nxt = S_I_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_nxt = S_FETCH;
         S_HALT:     state_nxt = S_HALT;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Only a DECODE that falls straight back to FETCH is an undecodable instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         ctrl_q    <= ctrl_for(state_nxt, funct);
         illegal_q <= (state_q == S_DECODE) && (state_nxt == S_FETCH);
      end
   end

   assign in_fetch      = (state_q == S_FETCH);
   assign ir_write      = in_fetch & mem_ready;
   assign pc_write      = ctrl_q.pc_write | (in_fetch & mem_ready);
   assign pc_en         = pc_write | (ctrl_q.pc_write_cond & zero);
   assign pc_write_cond = ctrl_q.pc_write_cond;
   assign i_or_d        = ctrl_q.i_or_d;
   assign mem_read      = ctrl_q.mem_read;
   assign mem_write     = ctrl_q.mem_write;
   assign reg_write     = ctrl_q.reg_write;
   assign reg_dst       = ctrl_q.reg_dst;
   assign mem_to_reg    = ctrl_q.mem_to_reg;
   assign alu_src_a     = ctrl_q.alu_src_a;
   assign alu_src_b     = ctrl_q.alu_src_b;
   assign alu_ctrl      = ctrl_q.alu_ctrl;
   assign pc_source     = ctrl_q.pc_source;
   assign halted        = ctrl_q.halted;
   assign illegal_op    = illegal_q;
   assign state         = state_q;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] instr_q;
   logic             retire;

   always_comb begin
      retire = 1'b0;
      if (state_nxt == S_FETCH) begin
         case (state_q)
            S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: retire = 1'b1;
            default: retire = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         if (state_q != S_IDLE && state_q != S_HALT)
            cycle_q <= cycle_q + CNT_W'(1);
         if (retire)
            instr_q <= instr_q + CNT_W'(1);
      end
   end

   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Main control FSM for the multi-cycle MIPS CPU. Sequences the shared datapath (single memory, single ALU, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and write-back cycles, driving every mux select and register enable. Supports memory wait states through a ready handshake. Sits inside `Top` between the instruction register fields and the datapath.

## Interface
- `HALT_OPCODE`, 6'h3F: opcode that parks the CPU in HALT.
- `CNT_W`, 32: width of the performance counters.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory access completes this cycle.
- `pc_en`  out  1  PC load = pc_write | (pc_write_cond & zero).
- `pc_write`, `pc_write_cond`  out  1  unconditional / branch PC write.
- `i_or_d`  out  1  memory address: 0=PC, 1=ALUOut.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `ir_write`  out  1  IR load.
- `reg_write`  out  1  register file write.
- `reg_dst`  out  1  0=rt, 1=rd.
- `mem_to_reg`  out  1  0=ALUOut, 1=MDR.
- `alu_src_a`  out  1  0=PC, 1=A.
- `alu_src_b`  out  2  00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2.
- `alu_ctrl`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_source`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `state`  out  4  current state encoding (debug).
- `illegal_op`  out  1  one-cycle registered pulse on undecodable instruction.
- `halted`  out  1  high in HALT.
- `cycle_cnt`, `instr_cnt`  out  CNT_W  performance counters.

## Operation
- States (encoding): IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, I_EXEC 11, I_WB 12, HALT 13.
- Reset: state=IDLE, every output 0. IDLE -> FETCH unconditionally.
- FETCH: mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, add, pc_source=00; ir_write=pc_write=mem_ready. Holds while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next by opcode: 0x00 with funct in {20,22,24,25,2A} -> R_EXEC; 0x23/0x2B -> MEM_ADDR; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> I_EXEC; HALT_OPCODE -> HALT; anything else -> FETCH with illegal_op pulsed next cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add; -> MEM_RD (0x23) or MEM_WR (0x2B).
- MEM_RD: mem_read, i_or_d=1; holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write, reg_dst=0, mem_to_reg=1; -> FETCH.
- MEM_WR: mem_write, i_or_d=1; holds until mem_ready, then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (20 add, 22 sub, 24 and, 25 or, 2A slt); -> R_WB.
- R_WB: reg_write, reg_dst=1, mem_to_reg=0; -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond, pc_source=01; -> FETCH.
- JUMP: pc_write, pc_source=10; -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, add; -> I_WB. I_WB: reg_write, reg_dst=0, mem_to_reg=0; -> FETCH.
- HALT: all strobes 0, halted=1; left only by rst.
- Unlisted outputs are 0 in each state; alu_ctrl defaults to add.

## Timing
- Outputs are decoded from the state register; only ir_write, pc_write, pc_en (FETCH) depend combinationally on mem_ready/zero.
- Cycles per instruction with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each low mem_ready cycle in FETCH/MEM_RD/MEM_WR adds one.
- rst asserted mid-instruction: immediate return to IDLE, all outputs 0 in the same cycle; no partial write completes.
- First FETCH is the second rising edge after rst deasserts.

## Configuration
- `CTRL_PERF_CNT_EN` defined: cycle_cnt increments every cycle not in IDLE/HALT; instr_cnt increments on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB; both wrap modulo 2^CNT_W, reset to 0.
- Undefined: counter logic absent, cycle_cnt/instr_cnt tied to 0; ports remain.

## Test plan
- Reset then lw (opcode 0x23), mem_ready=1 -> states 0,1,2,3,4,5,1; reg_write=1 with mem_to_reg=1 in state 5; instr_cnt=1.
- beq with zero=1 then zero=0 -> pc_en=1 in BRANCH first time, 0 second; pc_source=01, alu_ctrl=110.
- sw with mem_ready low 3 cycles in MEM_WR -> mem_write held 4 cycles, then FETCH; cycle_cnt=7.
- R-type funct 0x2A -> alu_ctrl=111 in R_EXEC, reg_dst=1 in R_WB; funct 0x03 -> back to FETCH, illegal_op one cycle.
- Opcode 0x3F -> HALT, halted=1, cycle_cnt frozen; rst pulse during MEM_RD -> all outputs 0 immediately, state 0.
